membus_arbiter: RTL and testbench

Parametrised memory-bus arbiter that multiplexes up to eight bus masters (host register-bus bridge, layer renderers, sprite engine, …) onto the single 32-bit video memory bus feeding main RAM and character ROM. It replaces the fixed two-way, hard-wired priority mux at top level. It adds explicit byte enables, selectable fixed or round-robin priority among the non-host masters, and a latency-matched acknowledge pipeline that tags returning read data to the master that issued it.

---
 rtl/membus_pkg.sv | 18 +
 rtl/membus_arbiter_rr.sv | 66 ++++++
 rtl/membus_arbiter.sv | 78 +++++++
 tb/tb_membus_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// membus_pkg - shared widths and channel constants for the video memory bus
// Rev 1.0
//------------------------------------------------------------------
package membus_pkg;

  localparam int MEMBUS_DW      = 32;
  localparam int MEMBUS_BSW     = 4;
  localparam int MEMBUS_CH_HOST = 0;

  // Width of a channel index; never below 1 so a 2-channel bus still has a register.
  function automatic int membus_chw(input int num_masters);
    return (num_masters > 2) ? $clog2(num_masters) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/membus_arbiter_rr.sv
`default_nettype none
//------------------------------------------------------------------
// rr_arbiter - one-hot grant with host override and round-robin/fixed priority
// Rev 1.0
//------------------------------------------------------------------
module rr_arbiter
  import membus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int RR_MODE     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant
);

  localparam int CHW = membus_chw(NUM_MASTERS);

  logic [CHW-1:0]         rr_ptr;
  logic [CHW-1:0]         ptr_next;
  logic [NUM_MASTERS-1:0] cand;
  logic [NUM_MASTERS-1:0] upper;
  logic [NUM_MASTERS-1:0] cand_hi;
  logic [NUM_MASTERS-1:0] pick_hi;
  logic [NUM_MASTERS-1:0] pick_all;

  // Round-robin as two lowest-bit picks: candidates at/after rr_ptr first, else wrap.
  always_comb begin
    cand                 = req;
    cand[MEMBUS_CH_HOST] = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      upper[i] = (CHW'(i) >= rr_ptr);
    end
    cand_hi  = cand & upper;
    pick_hi  = cand_hi & (-cand_hi);
    pick_all = cand & (-cand);
    grant    = '0;
    if (req[MEMBUS_CH_HOST]) begin
      grant[MEMBUS_CH_HOST] = 1'b1;
    end else if ((RR_MODE != 0) && (cand_hi != '0)) begin
      grant = pick_hi;
    end else begin
      grant = pick_all;
    end
  end

  always_comb begin
    ptr_next = rr_ptr;
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        ptr_next = (i == NUM_MASTERS - 1) ? CHW'(1) : CHW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= CHW'(1);
    end else begin
      rr_ptr <= ptr_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/membus_arbiter.sv
`default_nettype none
//------------------------------------------------------------------
// membus_arbiter - N-master arbiter onto the 32-bit video memory bus with ack pipeline
// Rev 1.0
//------------------------------------------------------------------
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 18,
  parameter int RD_LATENCY  = 1,
  parameter int RR_MODE     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_strobe,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*MEMBUS_DW-1:0]  m_wrdata,
  input  logic [NUM_MASTERS*MEMBUS_BSW-1:0] m_bytesel,
  output logic [NUM_MASTERS-1:0]            m_grant,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [MEMBUS_DW-1:0]              m_rddata,
  output logic                              s_strobe,
  output logic                              s_write,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [MEMBUS_DW-1:0]              s_wrdata,
  output logic [MEMBUS_BSW-1:0]             s_bytesel,
  input  logic [MEMBUS_DW-1:0]              s_rddata
);

  logic [RD_LATENCY-1:0][NUM_MASTERS-1:0] ack_pipe;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .RR_MODE     (RR_MODE)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (m_strobe),
    .grant (m_grant)
  );

  // Only the granted channel reaches the slave; everything is zero when idle.
  always_comb begin
    s_write   = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_bytesel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (m_grant[i]) begin
        s_write   = m_write[i];
        s_addr    = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wrdata  = m_wrdata[i*MEMBUS_DW +: MEMBUS_DW];
        s_bytesel = m_bytesel[i*MEMBUS_BSW +: MEMBUS_BSW];
      end
    end
  end

  assign s_strobe = |m_strobe;

  // Reads and writes share one delay line so every grant returns exactly one ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_pipe <= '0;
    end else begin
      ack_pipe[0] <= m_grant;
      for (int j = 1; j < RD_LATENCY; j++) begin
        ack_pipe[j] <= ack_pipe[j-1];
      end
    end
  end

  assign m_ack    = ack_pipe[RD_LATENCY-1];
  assign m_rddata = s_rddata;

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
//------------------------------------------------------------------
// tb_membus_arbiter - directed and random checks of two arbiter configurations
// Rev 1.0
//------------------------------------------------------------------
module tb_membus_arbiter;

  localparam int N    = 4;
  localparam int AW   = 18;
  localparam int LOGD = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    m_strobe  = '0;
  logic [N-1:0]    m_write   = '0;
  logic [N*AW-1:0] m_addr    = '0;
  logic [N*32-1:0] m_wrdata  = '0;
  logic [N*4-1:0]  m_bytesel = '0;
  logic [31:0]     s_rddata  = '0;

  logic [N-1:0]  ga, gb, acka, ackb;
  logic [31:0]   rda, rdb, swda, swdb;
  logic          ssa, ssb, swa, swb;
  logic [AW-1:0] saa, sab;
  logic [3:0]    sba, sbb;

  membus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RR_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .m_strobe(m_strobe), .m_write(m_write), .m_addr(m_addr),
    .m_wrdata(m_wrdata), .m_bytesel(m_bytesel), .m_grant(ga), .m_ack(acka),
    .m_rddata(rda), .s_strobe(ssa), .s_write(swa), .s_addr(saa), .s_wrdata(swda),
    .s_bytesel(sba), .s_rddata(s_rddata)
  );

  membus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .RD_LATENCY(3), .RR_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .m_strobe(m_strobe), .m_write(m_write), .m_addr(m_addr),
    .m_wrdata(m_wrdata), .m_bytesel(m_bytesel), .m_grant(gb), .m_ack(ackb),
    .m_rddata(rdb), .s_strobe(ssb), .s_write(swb), .s_addr(sab), .s_wrdata(swdb),
    .s_bytesel(sbb), .s_rddata(s_rddata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-channel master state
  bit            c_stb [N];
  bit            c_wr  [N];
  logic [AW-1:0] c_addr[N];
  logic [31:0]   c_data[N];
  logic [3:0]    c_bs  [N];

  // Reference model state (index 0 = dut_a, 1 = dut_b)
  int           lat[2] = '{1, 3};
  bit           rrm[2] = '{1'b1, 1'b0};
  int           ptr[2];
  int           cyc = 0;
  int           rst_cyc = 0;
  logic [N-1:0] gr_log[2][LOGD];
  bit           wr_log[2][LOGD];

  // Snapshots of DUT outputs taken in the mid-cycle window
  logic [N-1:0]  sn_g[2], sn_ack[2];
  logic [31:0]   sn_rd[2], sn_wd[2];
  logic          sn_ss[2], sn_sw[2];
  logic [AW-1:0] sn_sa[2];
  logic [3:0]    sn_bs[2];

  function automatic logic [N-1:0] model_grant(input bit rr, input int p, input logic [N-1:0] req);
    logic [N-1:0] one = 1;
    int ch;
    if (req[0]) return one;
    for (int off = 0; off < N - 1; off++) begin
      ch = rr ? ((p - 1 + off) % (N - 1)) + 1 : off + 1;
      if (req[ch]) return one << ch;
    end
    return '0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      m_strobe[i]           = c_stb[i];
      m_write[i]            = c_wr[i];
      m_addr[i*AW +: AW]    = c_addr[i];
      m_wrdata[i*32 +: 32]  = c_data[i];
      m_bytesel[i*4 +: 4]   = c_bs[i];
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      c_stb[i] = 1'b0; c_wr[i] = 1'b0; c_addr[i] = '0; c_data[i] = '0; c_bs[i] = '0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0]  eg, eack;
    logic          ew;
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    logic [3:0]    eb;
    int            c;
    string         sfx;
    drive();
    #1;
    sn_g[0] = ga;   sn_ack[0] = acka; sn_rd[0] = rda; sn_wd[0] = swda;
    sn_ss[0] = ssa; sn_sw[0] = swa;   sn_sa[0] = saa; sn_bs[0] = sba;
    sn_g[1] = gb;   sn_ack[1] = ackb; sn_rd[1] = rdb; sn_wd[1] = swdb;
    sn_ss[1] = ssb; sn_sw[1] = swb;   sn_sa[1] = sab; sn_bs[1] = sbb;
    chk("rr_ptr_a", dut_a.u_rr.rr_ptr, ptr[0]);
    for (int d = 0; d < 2; d++) begin
      sfx = (d == 0) ? "_a" : "_b";
      eg = model_grant(rrm[d], ptr[d], m_strobe);
      ew = 1'b0; ea = '0; ed = '0; eb = '0;
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          ew = c_wr[i]; ea = c_addr[i]; ed = c_data[i]; eb = c_bs[i];
        end
      end
      chk({"grant", sfx}, sn_g[d], eg);
      chk({"s_strobe", sfx}, sn_ss[d], |m_strobe);
      chk({"s_write", sfx}, sn_sw[d], ew);
      chk({"s_addr", sfx}, sn_sa[d], ea);
      chk({"s_wrdata", sfx}, sn_wd[d], ed);
      chk({"s_bytesel", sfx}, sn_bs[d], eb);
      c = cyc - lat[d];
      eack = (c >= rst_cyc) ? gr_log[d][c] : '0;
      chk({"ack", sfx}, sn_ack[d], eack);
      if (eack != '0 && !wr_log[d][c]) chk({"rddata", sfx}, sn_rd[d], s_rddata);
      gr_log[d][cyc] = eg;
      wr_log[d][cyc] = ew;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 1; i < N; i++) begin
        if (gr_log[d][cyc][i]) ptr[d] = (i == N - 1) ? 1 : i + 1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_all();
    drive();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr[0] = 1; ptr[1] = 1;
    rst_cyc = cyc;
  endtask

  initial begin
    logic [N-1:0] one = 1;
    logic [N-1:0] prev;

    // Reset state
    do_reset();
    chk("rst_rr_ptr", dut_a.u_rr.rr_ptr, 1);
    cycle();
    chk("rst_s_strobe", sn_ss[0], 0);
    chk("rst_s_addr", sn_sa[0], 0);
    chk("rst_ack_a", sn_ack[0], 0);
    chk("rst_ack_b", sn_ack[1], 0);

    // Single channel-1 read, latency 1
    c_stb[1] = 1'b1; c_addr[1] = 18'h00104; s_rddata = $urandom;
    cycle();
    chk("rd1_grant", sn_g[0], 4'b0010);
    chk("rd1_s_addr", sn_sa[0], 18'h00104);
    c_stb[1] = 1'b0; s_rddata = 32'hDEADBEEF;
    cycle();
    chk("rd1_ack", sn_ack[0], 4'b0010);
    chk("rd1_rddata", sn_rd[0], 32'hDEADBEEF);

    // Host and channel 2 collide
    c_stb[0] = 1'b1; c_stb[2] = 1'b1;
    cycle();
    chk("host_first", sn_g[0], 4'b0001);
    c_stb[0] = 1'b0;
    cycle();
    chk("ch2_second", sn_g[0], 4'b0100);
    chk("host_ack", sn_ack[0], 4'b0001);
    c_stb[2] = 1'b0;
    cycle();
    chk("ch2_ack", sn_ack[0], 4'b0100);

    // Continuous requests on 1..3: rotation vs fixed priority
    do_reset();
    c_stb[1] = 1'b1; c_stb[2] = 1'b1; c_stb[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rot_rr", sn_g[0], one << ((k % 3) + 1));
      chk("rot_fixed", sn_g[1], 4'b0010);
    end
    idle_all();
    cycle();

    // Channel 3 byte write, acked at latency 1 and 3
    repeat (3) cycle();
    c_stb[3] = 1'b1; c_wr[3] = 1'b1; c_addr[3] = 18'h00012;
    c_bs[3] = 4'b0100; c_data[3] = 32'h00AB0000;
    cycle();
    chk("wr_s_write", sn_sw[0], 1);
    chk("wr_s_bytesel", sn_bs[0], 4'b0100);
    chk("wr_s_wrdata", sn_wd[1], 32'h00AB0000);
    idle_all();
    cycle();
    chk("wr_ack_lat1", sn_ack[0], 4'b1000);
    chk("wr_noack_lat3_early", sn_ack[1], 0);
    cycle();
    cycle();
    chk("wr_ack_lat3", sn_ack[1], 4'b1000);

    // Reset while a latency-3 read is in flight
    c_stb[1] = 1'b1;
    cycle();
    c_stb[1] = 1'b0;
    cycle();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rst_flush_b", sn_ack[1], 0);
    end
    c_stb[2] = 1'b1;
    cycle();
    c_stb[2] = 1'b0;
    repeat (3) cycle();
    chk("post_rst_ack_b", sn_ack[1], 4'b0100);

    // Random traffic; masters hold requests until granted (judged by the rotating config)
    for (int t = 0; t < 2000; t++) begin
      if (t % 700 == 699) do_reset();
      prev = (cyc > rst_cyc) ? gr_log[0][cyc-1] : '0;
      for (int i = 0; i < N; i++) begin
        if (!c_stb[i] || prev[i]) begin
          c_stb[i]  = ($urandom_range(0, 99) < ((i == 0) ? 20 : 60));
          c_wr[i]   = 1'($urandom_range(0, 1));
          c_addr[i] = AW'($urandom);
          c_data[i] = $urandom;
          c_bs[i]   = 4'($urandom);
        end
      end
      s_rddata = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
